// File: rtl/idma_error_sequencer.sv
// idma_error_sequencer: central error-handling controller for the iDMA backend.
// Arbitrates error reports from four origins (bus read, bus write, backend,
// nd-midend) round-robin and presents one error at a time to the frontend.
// It then waits for the frontend's CONTINUE/ABORT decision and dispatches it
// back to the originating unit.
//
// Optional feature macro: IDMA_ERR_SEQ_CNT_EN
//   defined   -> saturating capture counter drives err_cnt_o
//   undefined -> no counter register, err_cnt_o tied to 0
module idma_error_sequencer #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  // error sources, index = err_type_e
  input  logic [3:0]             src_valid_i,
  input  logic [4*AddrWidth-1:0] src_addr_i,
  output logic [3:0]             src_ready_o,
  // error report towards the frontend
  output logic                   err_valid_o,
  input  logic                   err_ready_i,
  output logic [1:0]             err_type_o,
  output logic [AddrWidth-1:0]   err_addr_o,
  // error-handling action from the frontend (0 = CONTINUE, 1 = ABORT)
  input  logic                   eh_req_valid_i,
  input  logic                   eh_req_i,
  output logic                   eh_req_ready_o,
  // action dispatch towards the originating source
  output logic [3:0]             act_valid_o,
  output logic                   act_o,
  input  logic [3:0]             act_ready_i,
  // status
  output logic                   eh_fsm_busy_o,
  output logic [CntWidth-1:0]    err_cnt_o
);

  localparam logic [1:0] StIdle       = 2'd0;
  localparam logic [1:0] StReport     = 2'd1;
  localparam logic [1:0] StWaitAction = 2'd2;
  localparam logic [1:0] StDispatch   = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [1:0]           rr_q, rr_d;
  logic [1:0]           type_q, type_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 act_q, act_d;
  logic                 busy_q;

  logic [AddrWidth-1:0] src_addr [4];
  logic                 grant_vld;
  logic [1:0]           grant_idx;
  logic [1:0]           cand;
  logic                 capture;
  logic [3:0]           type_onehot;

  // Unpack the flat per-source address bus.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      src_addr[i] = src_addr_i[i*AddrWidth +: AddrWidth];
    end
  end

  // Round-robin pick: first pending source at or after rr_q. Scanning the
  // offsets from far to near lets the nearest pending source win.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr_q;
    cand      = rr_q;
    for (int i = 3; i >= 0; i--) begin
      cand = rr_q + 2'(i);
      if (src_valid_i[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // A capture never happens in a reset cycle, so the pulse is suppressed there
  // to keep sources from believing their error was taken.
  assign capture     = (state_q == StIdle) && grant_vld && !rst_i;
  assign type_onehot = 4'b0001 << type_q;

  // Handshake outputs decoded from the current state.
  always_comb begin
    src_ready_o    = capture ? (4'b0001 << grant_idx) : 4'b0000;
    err_valid_o    = (state_q == StReport);
    eh_req_ready_o = (state_q == StWaitAction);
    act_valid_o    = (state_q == StDispatch) ? type_onehot : 4'b0000;
  end

  assign err_type_o    = type_q;
  assign err_addr_o    = addr_q;
  assign act_o         = act_q;
  assign eh_fsm_busy_o = busy_q;

  // Next-state logic for the error-handling loop and its captured payload.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    type_d  = type_q;
    addr_d  = addr_q;
    act_d   = act_q;
    unique case (state_q)
      StIdle: begin
        if (capture) begin
          type_d  = grant_idx;
          addr_d  = src_addr[grant_idx];
          rr_d    = grant_idx + 2'd1;
          state_d = StReport;
        end
      end
      StReport: begin
        if (err_ready_i) state_d = StWaitAction;
      end
      StWaitAction: begin
        if (eh_req_valid_i) begin
          act_d   = eh_req_i;
          state_d = StDispatch;
        end
      end
      StDispatch: begin
        // Only the originating source may complete the dispatch.
        if (act_ready_i[type_q]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and payload registers; busy is registered off the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      rr_q    <= 2'd0;
      type_q  <= 2'd0;
      addr_q  <= '0;
      act_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      act_q   <= act_d;
      busy_q  <= (state_d != StIdle);
    end
  end

`ifdef IDMA_ERR_SEQ_CNT_EN
  logic [CntWidth-1:0] cnt_q, cnt_d;

  // Saturating count of captured errors; cleared only by reset.
  always_comb begin
    cnt_d = cnt_q;
    if (capture && (cnt_q != {CntWidth{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign err_cnt_o = cnt_q;
`else
  assign err_cnt_o = '0;
`endif

`ifndef SYNTHESIS
  // At most one source is granted and at most one source sees an action.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert ($onehot0(src_ready_o));
      assert ($onehot0(act_valid_o));
    end
  end
`endif

endmodule

// File: tb/tb_idma_error_sequencer.sv
// Table-driven bench for idma_error_sequencer. Each table row is one clock
// cycle: inputs are driven on the falling edge and all outputs are compared
// 1 ns later, before the next rising edge.
module tb_idma_error_sequencer;
  localparam int unsigned AW = 64;
  localparam int unsigned CW = 2;
  localparam int CntMax = (1 << CW) - 1;
`ifdef IDMA_ERR_SEQ_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  localparam logic [63:0] A0 = 64'hDEAD_BEEF_0000_0000;
  localparam logic [63:0] A1 = 64'h0000_0000_0000_1000;
  localparam logic [63:0] A2 = 64'h2222_0000_0000_2222;
  localparam logic [63:0] A3 = 64'h0000_0033_3300_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    src_valid = 4'b0;
  logic [4*AW-1:0] src_addr;
  logic [3:0]    src_ready;
  logic          err_valid;
  logic          err_ready = 1'b0;
  logic [1:0]    err_type;
  logic [AW-1:0] err_addr;
  logic          eh_valid = 1'b0;
  logic          eh_req = 1'b0;
  logic          eh_ready;
  logic [3:0]    act_valid;
  logic          act;
  logic [3:0]    act_ready = 4'b0;
  logic          busy;
  logic [CW-1:0] err_cnt;

  always #5 clk = ~clk;

  assign src_addr = {A3, A2, A1, A0};

  idma_error_sequencer #(
    .AddrWidth(AW),
    .CntWidth (CW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .src_valid_i   (src_valid),
    .src_addr_i    (src_addr),
    .src_ready_o   (src_ready),
    .err_valid_o   (err_valid),
    .err_ready_i   (err_ready),
    .err_type_o    (err_type),
    .err_addr_o    (err_addr),
    .eh_req_valid_i(eh_valid),
    .eh_req_i      (eh_req),
    .eh_req_ready_o(eh_ready),
    .act_valid_o   (act_valid),
    .act_o         (act),
    .act_ready_i   (act_ready),
    .eh_fsm_busy_o (busy),
    .err_cnt_o     (err_cnt)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  sv;
    logic        er;
    logic        ehv;
    logic        ehq;
    logic [3:0]  ar;
    logic [3:0]  e_sr;
    logic        e_ev;
    logic [1:0]  e_ty;
    logic [63:0] e_ad;
    logic        e_ehr;
    logic [3:0]  e_av;
    logic        e_act;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   m_cnt  = 0;

  function automatic vec_t mk(input logic rst_v, input logic [3:0] sv, input logic er,
                              input logic ehv, input logic ehq, input logic [3:0] ar,
                              input logic [3:0] e_sr, input logic e_ev, input logic [1:0] e_ty,
                              input logic [63:0] e_ad, input logic e_ehr,
                              input logic [3:0] e_av, input logic e_act, input logic e_busy);
    vec_t v;
    v.rst = rst_v; v.sv = sv; v.er = er; v.ehv = ehv; v.ehq = ehq; v.ar = ar;
    v.e_sr = e_sr; v.e_ev = e_ev; v.e_ty = e_ty; v.e_ad = e_ad; v.e_ehr = e_ehr;
    v.e_av = e_av; v.e_act = e_act; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [63:0] got,
                     input logic [63:0] exp);
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s row %0d: got %0h, expected %0h", nm, idx, got, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    int exp_cnt;
    @(negedge clk);
    rst       = v.rst;
    src_valid = v.sv;
    err_ready = v.er;
    eh_valid  = v.ehv;
    eh_req    = v.ehq;
    act_ready = v.ar;
    #1;
    n_vec++;
    exp_cnt = CntEn ? m_cnt : 0;
    chk("src_ready", idx, 64'(src_ready), 64'(v.e_sr));
    chk("err_valid", idx, 64'(err_valid), 64'(v.e_ev));
    chk("err_type",  idx, 64'(err_type),  64'(v.e_ty));
    chk("err_addr",  idx, err_addr,       v.e_ad);
    chk("eh_ready",  idx, 64'(eh_ready),  64'(v.e_ehr));
    chk("act_valid", idx, 64'(act_valid), 64'(v.e_av));
    chk("act",       idx, 64'(act),       64'(v.e_act));
    chk("busy",      idx, 64'(busy),      64'(v.e_busy));
    chk("err_cnt",   idx, 64'(err_cnt),   64'(exp_cnt));
    // Counter model advances on the upcoming rising edge.
    if (v.rst) m_cnt = 0;
    else if (v.e_sr != 4'b0 && m_cnt < CntMax) m_cnt++;
  endtask

  initial begin
    // Reset state right after reset.
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0));
    // BUS_WRITE at 0x1000, immediate partners, ABORT.
    tbl.push_back(mk(0, 4'b0010, 0, 0, 0, 4'b0000, 4'b0010, 0, 0, 0,  0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 1, 1, A1, 0, 4'b0000, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 1, 1, 4'b0000, 4'b0000, 0, 1, A1, 1, 4'b0000, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0010, 4'b0000, 0, 1, A1, 0, 4'b0010, 1, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, A1, 0, 4'b0000, 1, 0));
    // Reset back to rr = 0, then all four sources at once.
    tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, A1, 0, 4'b0000, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b0000, 4'b0001, 0, 0, 0,  0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b1110, 1, 0, 0, 4'b0000, 4'b0000, 1, 0, A0, 0, 4'b0000, 0, 1));
    tbl.push_back(mk(0, 4'b1110, 0, 1, 0, 4'b0000, 4'b0000, 0, 0, A0, 1, 4'b0000, 0, 1));
    tbl.push_back(mk(0, 4'b1110, 0, 0, 0, 4'b0001, 4'b0000, 0, 0, A0, 0, 4'b0001, 0, 1));
    tbl.push_back(mk(0, 4'b1110, 0, 0, 0, 4'b0000, 4'b0010, 0, 0, A0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b1100, 1, 0, 0, 4'b0000, 4'b0000, 1, 1, A1, 0, 4'b0000, 0, 1));
    tbl.push_back(mk(0, 4'b1100, 0, 1, 0, 4'b0000, 4'b0000, 0, 1, A1, 1, 4'b0000, 0, 1));
    tbl.push_back(mk(0, 4'b1100, 0, 0, 0, 4'b0010, 4'b0000, 0, 1, A1, 0, 4'b0010, 0, 1));
    tbl.push_back(mk(0, 4'b1100, 0, 0, 0, 4'b0000, 4'b0100, 0, 1, A1, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b1000, 1, 0, 0, 4'b0000, 4'b0000, 1, 2, A2, 0, 4'b0000, 0, 1));
    tbl.push_back(mk(0, 4'b1000, 0, 1, 1, 4'b0000, 4'b0000, 0, 2, A2, 1, 4'b0000, 0, 1));
    tbl.push_back(mk(0, 4'b1000, 0, 0, 0, 4'b0100, 4'b0000, 0, 2, A2, 0, 4'b0100, 1, 1));
    tbl.push_back(mk(0, 4'b1000, 0, 0, 0, 4'b0000, 4'b1000, 0, 2, A2, 0, 4'b0000, 1, 0));
    tbl.push_back(mk(0, 4'b0001, 1, 0, 0, 4'b0000, 4'b0000, 1, 3, A3, 0, 4'b0000, 1, 1));
    tbl.push_back(mk(0, 4'b0001, 0, 1, 0, 4'b0000, 4'b0000, 0, 3, A3, 1, 4'b0000, 1, 1));
    tbl.push_back(mk(0, 4'b0001, 0, 0, 0, 4'b1000, 4'b0000, 0, 3, A3, 0, 4'b1000, 0, 1));
    // Pointer wrapped to 0: source 0 wins over pending source 2.
    tbl.push_back(mk(0, 4'b0101, 0, 0, 0, 4'b0000, 4'b0001, 0, 3, A3, 0, 4'b0000, 0, 0));
    // Frontend stalls REPORT 10 cycles; ABORT pulses there must be ignored.
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(0, 4'b0100, 0, 1'(k % 2), 1, 4'b0000,
                       4'b0000, 1, 0, A0, 0, 4'b0000, 0, 1));
    tbl.push_back(mk(0, 4'b0100, 1, 0, 0, 4'b0000, 4'b0000, 1, 0, A0, 0, 4'b0000, 0, 1));
    tbl.push_back(mk(0, 4'b0100, 0, 1, 0, 4'b0000, 4'b0000, 0, 0, A0, 1, 4'b0000, 0, 1));
    // DISPATCH: granted source late by 5 cycles, others ready meanwhile.
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0, 4'b0100, 0, 0, 0, 4'b1110, 4'b0000, 0, 0, A0, 0, 4'b0001, 0, 1));
    tbl.push_back(mk(0, 4'b0100, 0, 0, 0, 4'b0001, 4'b0000, 0, 0, A0, 0, 4'b0001, 0, 1));
    tbl.push_back(mk(0, 4'b0100, 0, 0, 0, 4'b0000, 4'b0100, 0, 0, A0, 0, 4'b0000, 0, 0));
    // Source 2 completes with waits on every partner.
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 1, 2, A2, 0, 4'b0000, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 1, 2, A2, 0, 4'b0000, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 2, A2, 1, 4'b0000, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 1, 1, 4'b0000, 4'b0000, 0, 2, A2, 1, 4'b0000, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 2, A2, 0, 4'b0100, 1, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0100, 4'b0000, 0, 2, A2, 0, 4'b0100, 1, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 2, A2, 0, 4'b0000, 1, 0));

    repeat (2) @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Reset while waiting for the action: rr_q is 3 here, so source 1 is
    // granted and the pointer moves to 2 before the reset hits.
    apply(mk(0, 4'b0010, 0, 0, 0, 4'b0000, 4'b0010, 0, 2, A2, 0, 4'b0000, 1, 0), 100);
    apply(mk(0, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 1, 1, A1, 0, 4'b0000, 1, 1), 101);
    apply(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, A1, 1, 4'b0000, 1, 1), 102);
    apply(mk(1, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, A1, 1, 4'b0000, 1, 1), 103);
    // Cleared payload, idle, and rr_q back at 0 so source 0 beats source 2.
    apply(mk(0, 4'b0101, 0, 0, 0, 4'b0000, 4'b0001, 0, 0, 0,  0, 4'b0000, 0, 0), 104);
    apply(mk(0, 4'b0100, 0, 0, 0, 4'b0000, 4'b0000, 1, 0, A0, 0, 4'b0000, 0, 1), 105);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
